// File: rtl/btn_ram_pkg.sv
// Shared FSM encoding and default parameter constants for the button/RAM toggler.
package btn_ram_pkg;

  localparam int unsigned DEF_NCH        = 3;
  localparam int unsigned DEF_AW         = 16;
  localparam int unsigned DEF_DW         = 32;
  localparam int unsigned DEF_BASE_ADDR  = 1;
  localparam int unsigned DEF_DEB_CYCLES = 500000;

  typedef enum logic [2:0] {
    ST_INIT_RD,
    ST_INIT_LD,
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability-window debouncer for one active-low button.
module btn_debounce
  import btn_ram_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNTW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic            sync1;
  logic            sync2;
  logic [CNTW-1:0] cnt;

  // Bring the asynchronous button into the clk domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Adopt the synchronized level only after it has disagreed for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (32'(cnt) == DEB_CYCLES - 1) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_ram_toggler.sv
// Debounced buttons toggle bit 0 of per-channel RAM words; LEDs mirror the stored bits.
module btn_ram_toggler
  import btn_ram_pkg::*;
#(
  parameter int unsigned    NCH        = DEF_NCH,
  parameter int unsigned    AW         = DEF_AW,
  parameter int unsigned    DW         = DEF_DW,
  parameter logic [AW-1:0]  BASE_ADDR  = AW'(DEF_BASE_ADDR),
  parameter int unsigned    DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] buttons,
  output logic [NCH-1:0] leds,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  input  logic [DW-1:0]  mem_rdata
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         state;
  state_e         state_nxt;
  logic [NCH-1:0] deb_level;
  logic [NCH-1:0] deb_press;
  logic [NCH-1:0] press_ev;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] pending_nxt;
  logic [NCH-1:0] overrun;
  logic [NCH-1:0] overrun_nxt;
  logic [NCH-1:0] leds_nxt;
  logic [CW-1:0]  scan_idx;
  logic [CW-1:0]  scan_nxt;
  logic [CW-1:0]  cur;
  logic [CW-1:0]  cur_nxt;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  rr_nxt;
  logic [CW-1:0]  cand;
  logic [CW-1:0]  grant_ch;
  logic           grant_vld;
  logic           scan_last;
  logic [AW-1:0]  addr_nxt;
  logic           we_nxt;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  wdata_nxt;
  logic [DW-1:0]  flip_data;

  // One synchronizer/debouncer per channel.
  for (genvar i = 0; i < NCH; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (buttons[i]),
      .level (deb_level[i]),
      .press (deb_press[i])
    );
  end

  // A press pulse always coincides with the debounced level going low.
  assign press_ev  = deb_press & ~deb_level;
  assign flip_data = mem_rdata ^ DW'(1);
  assign scan_last = (32'(scan_idx) == NCH - 1);

  // Read data only arrives in WR, so the write word is steered straight from the RAM then.
  assign mem_wdata = (state == ST_WR) ? flip_data : wdata_q;

  // Round-robin pick: first pending channel at or after rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = CW'((32'(rr_ptr) + k) % NCH);
      if (!grant_vld && pending[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT_RD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT_RD: state_nxt = ST_INIT_LD;
      ST_INIT_LD: state_nxt = scan_last ? ST_IDLE : ST_INIT_RD;
      ST_IDLE:    if (grant_vld) state_nxt = ST_RD;
      ST_RD:      state_nxt = ST_WR;
      ST_WR:      state_nxt = ST_IDLE;
      default:    state_nxt = ST_INIT_RD;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    scan_nxt    = scan_idx;
    cur_nxt     = cur;
    rr_nxt      = rr_ptr;
    addr_nxt    = mem_addr;
    we_nxt      = 1'b0;
    wdata_nxt   = wdata_q;
    leds_nxt    = leds;
    pending_nxt = pending;
    case (state)
      ST_INIT_LD: begin
        leds_nxt[scan_idx] = mem_rdata[0];
        if (!scan_last) begin
          scan_nxt = scan_idx + CW'(1);
          addr_nxt = BASE_ADDR + AW'(scan_idx) + AW'(1);
        end
      end
      ST_IDLE: begin
        if (grant_vld) begin
          cur_nxt  = grant_ch;
          addr_nxt = BASE_ADDR + AW'(grant_ch);
        end
      end
      ST_RD: we_nxt = 1'b1;
      ST_WR: begin
        wdata_nxt        = flip_data;
        leds_nxt[cur]    = flip_data[0];
        pending_nxt[cur] = 1'b0;
        rr_nxt           = (32'(cur) == NCH - 1) ? '0 : cur + CW'(1);
      end
      default: ;
    endcase
    // Applied after the service clear so a same-cycle press re-arms the channel.
    overrun_nxt = overrun | (press_ev & pending_nxt);
    pending_nxt = pending_nxt | press_ev;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      cur      <= '0;
      rr_ptr   <= '0;
      mem_addr <= BASE_ADDR;
      mem_we   <= 1'b0;
      wdata_q  <= '0;
      leds     <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      scan_idx <= scan_nxt;
      cur      <= cur_nxt;
      rr_ptr   <= rr_nxt;
      mem_addr <= addr_nxt;
      mem_we   <= we_nxt;
      wdata_q  <= wdata_nxt;
      leds     <= leds_nxt;
      pending  <= pending_nxt;
      overrun  <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_btn_ram_toggler.sv
// Randomized and directed bench for btn_ram_toggler with a cycle-level reference model.
module tb_btn_ram_toggler;

  localparam int NCH  = 3;
  localparam int DEB  = 4;
  localparam int BASE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  buttons = 3'b111;
  logic [2:0]  leds;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_ram_toggler #(
    .NCH        (NCH),
    .AW         (16),
    .DW         (32),
    .BASE_ADDR  (16'h0001),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buttons   (buttons),
    .leds      (leds),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Preload images: mode 0 has word 2 = A5A5_A5A4, mode 1 is all zero.
  function automatic logic [31:0] init_word(input int mode, input int a);
    if (mode == 0 && a == 2) return 32'hA5A5_A5A4;
    return 32'h0;
  endfunction

  // Synchronous RAM environment with a write log.
  logic [31:0] ram [16];
  int          ram_mode = 0;
  int          ram_mode_q = -1;
  logic [15:0] wlog_a [$];
  logic [31:0] wlog_d [$];
  int          wlog_t [$];
  int          cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (ram_mode != ram_mode_q) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(ram_mode, i);
      ram_mode_q <= ram_mode;
    end else if (mem_we) begin
      ram[mem_addr[3:0]] <= mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
      wlog_t.push_back(cyc_cnt);
    end
    mem_rdata <= ram[mem_addr[3:0]];
  end

  // Reference model state: what the outputs must be in the current cycle.
  int          m_scan;
  int          m_phase;
  int          m_ch;
  int          m_rr;
  bit [2:0]    m_pend;
  bit [2:0]    m_evt;
  bit [2:0]    m_lvl;
  bit [2:0]    m_leds;
  bit [15:0]   m_hist [NCH];
  logic [15:0] m_addr;
  logic [31:0] m_hold;
  logic [31:0] exp_ram [16];
  int          m_mode = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_reset();
    m_scan  = 0;
    m_phase = 0;
    m_ch    = 0;
    m_rr    = 0;
    m_pend  = '0;
    m_evt   = '0;
    m_lvl   = '1;
    m_leds  = '0;
    for (int c = 0; c < NCH; c++) m_hist[c] = '1;
    m_addr  = 16'(BASE);
    m_hold  = 32'h0;
    if (m_mode != ram_mode) begin
      for (int i = 0; i < 16; i++) exp_ram[i] = init_word(ram_mode, i);
      m_mode = ram_mode;
    end
  endtask

  task automatic model_check();
    logic [31:0] exp_wd;
    exp_wd = (m_phase == 2) ? (exp_ram[m_addr[3:0]] ^ 32'h1) : m_hold;
    check("leds", 32'(leds), 32'(m_leds));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_we", 32'(mem_we), 32'(m_phase == 2));
    check("mem_wdata", mem_wdata, exp_wd);
  endtask

  // Advance the model across one rising edge with button sample b.
  task automatic model_advance(input logic [2:0] b);
    logic [31:0] nw;
    bit [2:0]    old_evt;
    bit          found;
    bit          all_diff;
    old_evt = m_evt;
    if (m_scan < 2 * NCH) begin
      if (m_scan % 2 == 1) m_leds[m_scan / 2] = exp_ram[(BASE + m_scan / 2) % 16][0];
      m_scan++;
      if (m_scan < 2 * NCH) m_addr = 16'(BASE + m_scan / 2);
    end else if (m_phase == 0) begin
      if (m_pend != 0) begin
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_rr + k) % NCH;
          if (!found && m_pend[c]) begin
            m_ch  = c;
            found = 1'b1;
          end
        end
        m_phase = 1;
        m_addr  = 16'(BASE + m_ch);
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      nw = exp_ram[m_addr[3:0]] ^ 32'h1;
      exp_ram[m_addr[3:0]] = nw;
      m_hold = nw;
      m_leds[m_ch] = nw[0];
      m_pend[m_ch] = 1'b0;
      m_rr = (m_ch + 1) % NCH;
      m_phase = 0;
    end
    m_pend = m_pend | old_evt;
    // Debounce: flip when the last DEB synchronized samples (two edges old) all disagree.
    m_evt = '0;
    for (int c = 0; c < NCH; c++) begin
      m_hist[c] = {m_hist[c][14:0], b[c]};
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) if (m_hist[c][2 + j] == m_lvl[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c] == 1'b0) m_evt[c] = 1'b1;
      end
    end
  endtask

  // One clock: compare at the falling edge, then step to just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    model_check();
    if (rst_n) model_advance(buttons);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_for(input logic [2:0] lowmask, input int n);
    buttons = ~lowmask;
    ticks(n);
    buttons = 3'b111;
  endtask

  task automatic wait_phase(input int p, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(m_phase), 32'(p));
  endtask

  int base;
  int hold_cnt [NCH];
  logic [2:0] lv;

  initial begin
    model_reset();
    ticks(3);
    rst_n = 1'b1;

    // Power-up scan with the A5A4 image: all LEDs off, no writes.
    ticks(12);
    check("init_leds", 32'(leds), 32'h0);
    check("init_nowrite", 32'(wlog_a.size()), 32'd0);

    // Button 0 toggles word 1 on, then off again.
    press_for(3'b001, 10);
    ticks(15);
    check("b0_count", 32'(wlog_a.size()), 32'd1);
    check("b0_addr", 32'(wlog_a[0]), 32'd1);
    check("b0_data", wlog_d[0], 32'h1);
    check("b0_leds", 32'(leds), 32'b001);
    press_for(3'b001, 10);
    ticks(15);
    check("b0b_count", 32'(wlog_a.size()), 32'd2);
    check("b0b_data", wlog_d[1], 32'h0);
    check("b0b_leds", 32'(leds), 32'b000);

    // Bouncing button 1 yields exactly one write of the flipped A5A4 word.
    press_for(3'b010, 2);
    ticks(1);
    press_for(3'b010, 10);
    ticks(15);
    check("b1_count", 32'(wlog_a.size()), 32'd3);
    check("b1_addr", 32'(wlog_a[2]), 32'd2);
    check("b1_data", wlog_d[2], 32'hA5A5_A5A5);
    check("b1_leds", 32'(leds), 32'b010);

    // A glitch shorter than the window is ignored.
    press_for(3'b010, 3);
    ticks(15);
    check("glitch_nowrite", 32'(wlog_a.size()), 32'd3);

    // Fresh zero RAM, all three pressed together.
    rst_n = 1'b0;
    ram_mode = 1;
    ticks(3);
    rst_n = 1'b1;
    ticks(10);
    base = wlog_a.size();
    press_for(3'b111, 10);
    ticks(20);
    check("all_count", 32'(wlog_a.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("all_addr", 32'(wlog_a[base + i]), 32'(i + 1));
      check("all_data", wlog_d[base + i], 32'h1);
    end
    check("all_gap01", 32'(wlog_t[base + 1] - wlog_t[base]), 32'd3);
    check("all_gap12", 32'(wlog_t[base + 2] - wlog_t[base + 1]), 32'd3);
    check("all_leds", 32'(leds), 32'b111);

    // Random button activity against the model.
    lv = 3'b111;
    for (int c = 0; c < NCH; c++) hold_cnt[c] = 0;
    repeat (1500) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold_cnt[c] == 0) begin
          lv[c] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          hold_cnt[c] = int'($urandom_range(1, 12));
        end
        hold_cnt[c]--;
      end
      buttons = lv;
      tick();
    end
    buttons = 3'b111;
    ticks(40);

    // Reset during WR: write dropped, outputs cleared at once, scan repeats.
    buttons = 3'b110;
    wait_phase(2, "reach_wr");
    rst_n = 1'b0;
    buttons = 3'b111;
    base = wlog_a.size();
    #1;
    check("abort_wr_we", 32'(mem_we), 32'h0);
    check("abort_wr_leds", 32'(leds), 32'h0);
    ticks(3);
    rst_n = 1'b1;
    ticks(12);
    check("abort_wr_nowrite", 32'(wlog_a.size()), 32'(base));

    // Reset during RD.
    buttons = 3'b101;
    wait_phase(1, "reach_rd");
    rst_n = 1'b0;
    buttons = 3'b111;
    base = wlog_a.size();
    #1;
    check("abort_rd_we", 32'(mem_we), 32'h0);
    check("abort_rd_leds", 32'(leds), 32'h0);
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    check("abort_rd_nowrite", 32'(wlog_a.size()), 32'(base));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_ram_toggler.md
BTN_RAM_TOGGLER -- requirements
Module: btn_ram_toggler

Interface
REQ-001 SHALL have parameter NCH, default 3: number of button/LED channels (1..8).
REQ-002 SHALL have parameter AW, default 16: RAM word-address width.
REQ-003 SHALL have parameter DW, default 32: RAM data width.
REQ-004 SHALL have parameter BASE_ADDR, default 16'h0001: word address of channel 0; channel i uses BASE_ADDR+i.
REQ-005 SHALL have parameter DEB_CYCLES, default 500000: debounce stability window in clk cycles (10 ms at 50 MHz).
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port buttons  input  NCH  raw push buttons, active-low, asynchronous to clk.
REQ-009 SHALL have port leds  output  NCH  bit 0 of each channel's stored RAM word.
REQ-010 SHALL have port mem_addr  output  AW  RAM word address.
REQ-011 SHALL have port mem_wdata  output  DW  RAM write data.
REQ-012 SHALL have port mem_we  output  1  RAM write enable, one cycle per write.
REQ-013 SHALL have port mem_rdata  input  DW  RAM read data, valid one cycle after mem_addr (synchronous RAM).

Function
REQ-014 SHALL pass each button through a 2-FF synchronizer, then a debouncer whose stable level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
REQ-015 SHALL raise a one-cycle press event on a debounced 1->0 transition; releases produce no event.
REQ-016 SHALL set a per-channel pending flag on a press event; a press on an already-pending channel SHALL be dropped and set a sticky internal overrun bit for that channel.
REQ-017 SHALL implement FSM states INIT_RD, INIT_LD, IDLE, RD, WR.
REQ-018 After reset, SHALL scan channels 0..NCH-1 (INIT_RD drives addr, INIT_LD loads leds[i] from mem_rdata[0]), then enter IDLE; press events during the scan SHALL still set pending.
REQ-019 In IDLE with any pending flag, SHALL grant round-robin starting at the channel after the last one served (channel 0 first after reset).
REQ-020 Grant in IDLE at cycle k: RD at k+1 (mem_addr=BASE_ADDR+ch, mem_we=0); WR at k+2 (mem_we=1, same address, mem_wdata=mem_rdata with bit 0 inverted, other bits unchanged); IDLE at k+3 with leds[ch] updated and pending[ch] cleared.
REQ-021 A press event on the channel being serviced in the same cycle its pending clears SHALL re-set pending (not an overrun).
REQ-022 mem_we SHALL be high only in WR; mem_addr and mem_wdata SHALL hold their last value in IDLE.
REQ-023 Address arithmetic SHALL be modulo 2^AW (wrap-around permitted, no error).
REQ-024 Simultaneous presses on multiple channels SHALL all be serviced, one transaction each, in round-robin order; minimum spacing 3 cycles.

Reset
REQ-025 On rst_n low, asynchronously: FSM=INIT_RD, scan index 0, leds=0, pending=0, overrun=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, debounced levels=1 (released), debounce counters=0, RR pointer=0.
REQ-026 Reset asserted mid-transaction SHALL abort it with mem_we deasserted immediately; no partial write is retried.

Structure
REQ-027 FSM state enum and default parameter constants SHALL live in the shared package btn_ram_pkg.
REQ-028 The synchronizer+debouncer SHALL be a sub-module btn_debounce, instantiated NCH times, outputting stable level and press pulse.

Verification (bench: NCH=3, DEB_CYCLES=4, BASE_ADDR=1, RAM model preloaded 0)
REQ-029 Reset release -> three INIT reads at addr 1,2,3; leds=3'b000; no mem_we.
REQ-030 Button0 held low 10 cycles -> exactly one write addr 1, wdata 32'h1, leds[0]=1 at grant+3; second press -> wdata 32'h0, leds[0]=0.
REQ-031 Button1 bounces (low 2 cycles, high 1, low 10) -> exactly one write; bounce shorter than 4 cycles alone -> no write.
REQ-032 RAM word 2 preloaded 32'hA5A5_A5A4 -> after reset leds[1]=0; press -> wdata 32'hA5A5_A5A5, leds[1]=1.
REQ-033 All three buttons pressed same cycle -> writes to addr 1,2,3 in order, 3 cycles apart; leds=3'b111.
REQ-034 rst_n asserted in RD/WR cycle -> mem_we=0 same cycle, leds=0, INIT scan repeats after release.
